// File: rtl/serial_mod_checker_pkg.sv
// Shared types and elaboration helpers for the serial divisibility checker.
package serial_mod_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int MOD_MIN = 2;
    localparam int MOD_MAX = 255;

    function automatic int remWidth(input int m);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic bit modInRange(input int m);
        return (m >= MOD_MIN) && (m <= MOD_MAX);
    endfunction

endpackage

// File: rtl/serial_mod_checker_mod_add_reduce.sv
// Combinational (a + b) mod MOD for operands already reduced below MOD.
module mod_add_reduce #(
    parameter int MOD = 5,
    parameter int W   = 3
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    localparam logic [W:0] MOD_EXT = (W+1)'(MOD);

    logic [W:0] sum;
    logic [W:0] reduced;

    // Both operands are below MOD, so a single conditional subtract suffices.
    always_comb begin
        sum     = {1'b0, a_i} + {1'b0, b_i};
        reduced = (sum >= MOD_EXT) ? (sum - MOD_EXT) : sum;
        y_o     = reduced[W-1:0];
    end

endmodule

// File: rtl/serial_mod_checker.sv
// Serial bit-stream divisibility checker with start/last framing.
// Optional LSB-first mode enabled by defining SERIAL_MOD_LSB_EN.
module serial_mod_checker
    import serial_mod_pkg::*;
#(
    parameter int  MOD   = 5,
    parameter int  CNT_W = 16,
    localparam int RW    = remWidth(MOD)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             in_valid_i,
    input  logic             in_bit_i,
    input  logic             in_last_i,
`ifdef SERIAL_MOD_LSB_EN
    input  logic             lsb_first_i,
`endif
    output logic [RW-1:0]    rem_o,
    output logic             divisible_o,
    output logic [CNT_W-1:0] bit_count_o,
    output logic             done_o,
    output logic [RW-1:0]    res_rem_o,
    output logic             res_div_o
);

    if (!modInRange(MOD)) begin : gModCheck
        $fatal(1, "serial_mod_checker: MOD out of legal range 2..255");
    end

    localparam logic [RW:0]      MOD_EXT = (RW+1)'(MOD);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [RW-1:0]    resRem_q, resRem_d;
    logic             resDiv_q, resDiv_d;

    logic             accept;
    logic [RW-1:0]    remBase;
    logic [RW:0]      remPlusBit;
    logic [RW-1:0]    foldB;
    logic [RW-1:0]    remMsb;
    logic [RW-1:0]    remNew;

    assign accept     = in_valid_i && (start_i || (state_q == RUN));
    assign remBase    = start_i ? '0 : rem_q;
    assign remPlusBit = {1'b0, remBase} + {{RW{1'b0}}, in_bit_i};
    // 2*rem+bit is formed as rem + (rem+bit), with rem+bit folded back below MOD.
    assign foldB      = (remPlusBit == MOD_EXT) ? '0 : remPlusBit[RW-1:0];

    mod_add_reduce #(.MOD(MOD), .W(RW)) uMsbStep (
        .a_i (remBase),
        .b_i (foldB),
        .y_o (remMsb)
    );

`ifdef SERIAL_MOD_LSB_EN
    logic [RW-1:0] w_q, w_d;
    logic          lsb_q, lsb_d;
    logic [RW-1:0] wBase;
    logic          lsbMode;
    logic [RW-1:0] remLsb;
    logic [RW-1:0] wDoubled;

    assign wBase   = start_i ? RW'(1) : w_q;
    assign lsbMode = start_i ? lsb_first_i : lsb_q;

    mod_add_reduce #(.MOD(MOD), .W(RW)) uLsbStep (
        .a_i (remBase),
        .b_i (in_bit_i ? wBase : '0),
        .y_o (remLsb)
    );

    mod_add_reduce #(.MOD(MOD), .W(RW)) uWeightStep (
        .a_i (wBase),
        .b_i (wBase),
        .y_o (wDoubled)
    );

    assign remNew = lsbMode ? remLsb : remMsb;
    assign w_d    = accept ? wDoubled : wBase;
    assign lsb_d  = lsbMode;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            w_q   <= '0;
            lsb_q <= 1'b0;
        end else begin
            w_q   <= w_d;
            lsb_q <= lsb_d;
        end
    end
`else
    assign remNew = remMsb;
`endif

    // A start clears the frame first; a same-cycle valid bit then counts as bit one.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        resRem_d = resRem_q;
        resDiv_d = resDiv_q;
        if (start_i) begin
            state_d = RUN;
            rem_d   = '0;
            div_d   = 1'b0;
            cnt_d   = '0;
        end
        if (accept) begin
            rem_d = remNew;
            div_d = (remNew == '0);
            if (cnt_d != CNT_MAX) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
            if (in_last_i) begin
                done_d   = 1'b1;
                resRem_d = remNew;
                resDiv_d = (remNew == '0);
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            div_q    <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            resRem_q <= '0;
            resDiv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            resRem_q <= resRem_d;
            resDiv_q <= resDiv_d;
        end
    end

    assign rem_o       = rem_q;
    assign divisible_o = div_q;
    assign bit_count_o = cnt_q;
    assign done_o      = done_q;
    assign res_rem_o   = resRem_q;
    assign res_div_o   = resDiv_q;

endmodule

// File: tb/tb_serial_mod_checker.sv
// Bench for serial_mod_checker: MOD=5/CNT_W=16 and MOD=7/CNT_W=3 instances share stimulus.
module tb_serial_mod_checker;

    typedef struct {
        bit run;
        int rem;
        bit div;
        int cnt;
        bit done;
        int resRem;
        bit resDiv;
        bit lsb;
        int idx;
    } modelT;

    logic clk = 1'b0;
    logic resetN, start, inValid, inBit, inLast, lsbFirst;

    logic [2:0]  rem5, resRem5, rem7, resRem7;
    logic        div5, done5, resDiv5, div7, done7, resDiv7;
    logic [15:0] cnt5;
    logic [2:0]  cnt7;

    int    testsRun  = 0;
    int    failCount = 0;
    int    stepNo    = 0;
    modelT m5, m7;

    always #5 clk = ~clk;

    serial_mod_checker #(.MOD(5), .CNT_W(16)) dut5 (
        .clk_i(clk), .reset_n_i(resetN), .start_i(start), .in_valid_i(inValid),
        .in_bit_i(inBit), .in_last_i(inLast),
`ifdef SERIAL_MOD_LSB_EN
        .lsb_first_i(lsbFirst),
`endif
        .rem_o(rem5), .divisible_o(div5), .bit_count_o(cnt5), .done_o(done5),
        .res_rem_o(resRem5), .res_div_o(resDiv5)
    );

    serial_mod_checker #(.MOD(7), .CNT_W(3)) dut7 (
        .clk_i(clk), .reset_n_i(resetN), .start_i(start), .in_valid_i(inValid),
        .in_bit_i(inBit), .in_last_i(inLast),
`ifdef SERIAL_MOD_LSB_EN
        .lsb_first_i(lsbFirst),
`endif
        .rem_o(rem7), .divisible_o(div7), .bit_count_o(cnt7), .done_o(done7),
        .res_rem_o(resRem7), .res_div_o(resDiv7)
    );

    function automatic int pow2Mod(input int k, input int m);
        int r = 1 % m;
        for (int i = 0; i < k; i++) r = (r * 2) % m;
        return r;
    endfunction

    // Reference: remainder of the framed number, from plain arithmetic.
    function automatic modelT modelStep(input modelT m, input int modv, input int cntMax,
                                        input bit rstN, input bit st, input bit vld,
                                        input bit b, input bit lst, input bit lsbIn);
        modelT n = m;
        bit acc;
        n.done = 1'b0;
        if (!rstN) begin
            n = '{run: 0, rem: 0, div: 0, cnt: 0, done: 0, resRem: 0, resDiv: 0, lsb: 0, idx: 0};
            return n;
        end
        acc = vld && (st || m.run);
        if (st) begin
            n.run = 1'b1; n.rem = 0; n.div = 1'b0; n.cnt = 0; n.idx = 0; n.lsb = lsbIn;
        end
        if (acc) begin
            if (n.lsb) n.rem = (n.rem + (b ? pow2Mod(n.idx, modv) : 0)) % modv;
            else       n.rem = (2 * n.rem + int'(b)) % modv;
            n.idx++;
            n.div = (n.rem == 0);
            if (n.cnt < cntMax) n.cnt++;
            if (lst) begin
                n.done = 1'b1; n.resRem = n.rem; n.resDiv = n.div; n.run = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s step %0d: observed %0d expected %0d", tag, stepNo, observed, expected);
        end
    endtask

    task automatic checkBoth();
        checkOutput("d5.rem",    int'(rem5),    m5.rem);
        checkOutput("d5.div",    int'(div5),    int'(m5.div));
        checkOutput("d5.cnt",    int'(cnt5),    m5.cnt);
        checkOutput("d5.done",   int'(done5),   int'(m5.done));
        checkOutput("d5.resRem", int'(resRem5), m5.resRem);
        checkOutput("d5.resDiv", int'(resDiv5), int'(m5.resDiv));
        checkOutput("d7.rem",    int'(rem7),    m7.rem);
        checkOutput("d7.div",    int'(div7),    int'(m7.div));
        checkOutput("d7.cnt",    int'(cnt7),    m7.cnt);
        checkOutput("d7.done",   int'(done7),   int'(m7.done));
        checkOutput("d7.resRem", int'(resRem7), m7.resRem);
        checkOutput("d7.resDiv", int'(resDiv7), int'(m7.resDiv));
    endtask

    task automatic applyStimulus(input bit rstN, input bit st, input bit vld,
                                 input bit b, input bit lst, input bit lsb);
        resetN = rstN; start = st; inValid = vld; inBit = b; inLast = lst; lsbFirst = lsb;
        @(posedge clk);
        m5 = modelStep(m5, 5, 65535, rstN, st, vld, b, lst, lsb);
        m7 = modelStep(m7, 7, 7,     rstN, st, vld, b, lst, lsb);
        #1;
        stepNo++;
        checkBoth();
    endtask

    initial begin
        bit [9:0] longBits;
        bit       rStart, rValid, rLast, rRst, rLsb;
        m5 = '{run: 0, rem: 0, div: 0, cnt: 0, done: 0, resRem: 0, resDiv: 0, lsb: 0, idx: 0};
        m7 = m5;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 1, 0);
        checkOutput("reset.rem5", int'(rem5), 0);
        checkOutput("reset.cnt5", int'(cnt5), 0);

        // Frame 1010 on the modulus-5 instance: remainder walk 1,2,0,0
        applyStimulus(1, 1, 1, 1, 0, 0); checkOutput("p1.rem.b1", int'(rem5), 1);
        applyStimulus(1, 0, 1, 0, 0, 0); checkOutput("p1.rem.b2", int'(rem5), 2);
        applyStimulus(1, 0, 1, 1, 0, 0); checkOutput("p1.div.b3", int'(div5), 1);
        applyStimulus(1, 0, 1, 0, 1, 0);
        checkOutput("p1.done", int'(done5), 1);
        checkOutput("p1.resDiv", int'(resDiv5), 1);
        applyStimulus(1, 0, 1, 1, 1, 0);
        checkOutput("p1.doneOnce", int'(done5), 0);

        // 13: res_rem 3 for MOD=5, 6 for MOD=7
        applyStimulus(1, 1, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 1, 0);
        checkOutput("p2.resRem5", int'(resRem5), 3);
        checkOutput("p2.resRem7", int'(resRem7), 6);
        checkOutput("p2.cnt5", int'(cnt5), 4);

        // 7 then 14 back-to-back, start on the done cycle
        applyStimulus(1, 1, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 1, 0);
        checkOutput("p3.resRem7a", int'(resRem7), 0);
        applyStimulus(1, 1, 1, 1, 0, 0);
        checkOutput("p3.cntRestart", int'(cnt7), 1);
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 0);
        checkOutput("p3.resRem7b", int'(resRem7), 0);
        checkOutput("p3.resRem5b", int'(resRem5), 4);

        // Abort frame A (110) with frame B (11, last)
        applyStimulus(1, 1, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 0, 0);
        checkOutput("p4.noDone", int'(done5), 0);
        applyStimulus(1, 0, 1, 1, 1, 0);
        checkOutput("p4.resRem5", int'(resRem5), 3);

        // Reset mid-frame clears results too
        applyStimulus(1, 1, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 0);
        checkOutput("p5.resRem5", int'(resRem5), 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);

        // 10-bit frame 718: MOD=7 counter saturates at 7
        longBits = 10'b1011001110;
        for (int i = 9; i >= 0; i--) applyStimulus(1, (i == 9), 1, longBits[i], (i == 0), 0);
        checkOutput("p6.cnt7", int'(cnt7), 7);
        checkOutput("p6.cnt5", int'(cnt5), 10);
        checkOutput("p6.resRem7", int'(resRem7), 4);
        checkOutput("p6.resRem5", int'(resRem5), 3);

`ifdef SERIAL_MOD_LSB_EN
        // LSB-first 10: rem 0,2,2,0
        applyStimulus(1, 1, 1, 0, 0, 1); checkOutput("lsb.b1", int'(rem5), 0);
        applyStimulus(1, 0, 1, 1, 0, 0); checkOutput("lsb.b2", int'(rem5), 2);
        applyStimulus(1, 0, 1, 0, 0, 0); checkOutput("lsb.b3", int'(rem5), 2);
        applyStimulus(1, 0, 1, 1, 1, 0);
        checkOutput("lsb.resDiv", int'(resDiv5), 1);
`endif

        for (int i = 0; i < 400; i++) begin
            rRst   = ($urandom_range(0, 63) == 0);
            rStart = ($urandom_range(0, 11) == 0);
            rValid = ($urandom_range(0, 3) != 0);
            rLast  = ($urandom_range(0, 7) == 0);
`ifdef SERIAL_MOD_LSB_EN
            rLsb   = 1'($urandom_range(0, 1));
`else
            rLsb   = 1'b0;
`endif
            applyStimulus(!rRst, rStart, rValid, 1'($urandom_range(0, 1)), rLast, rLsb);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/serial_mod_checker.md
# serial_mod_checker

Parametrised serial divisibility checker: consumes a bit stream one bit per cycle, tracks the running remainder of the accumulated binary number modulo a compile-time modulus `MOD`, and reports a per-bit divisible flag plus a framed end-of-number result. It succeeds the fixed divide-by-5 FSM in the serial-arithmetic library and adds these capabilities:

- arbitrary modulus;
- explicit framing with `start`/`last`;
- a bit counter;
- an optional LSB-first mode.

## Interface
- `MOD`, 5, modulus; legal range 2..255.
- `CNT_W`, 16, width of the bit counter.
- `RW` (localparam), `$clog2(MOD)`, remainder width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  begin new frame (pulse).
- `in_valid`  in  1  `in_bit` is valid this cycle.
- `in_bit`  in  1  serial data bit.
- `in_last`  in  1  qualifies the accepted bit as the final bit of the frame.
- `rem`  out  RW  running remainder.
- `divisible`  out  1  running remainder is 0 and at least one bit has been accepted.
- `bit_count`  out  CNT_W  number of bits accepted in the current frame; saturating.
- `done`  out  1  one-cycle pulse after the last bit.
- `res_rem`  out  RW  remainder of the last completed frame.
- `res_div`  out  1  divisible flag of the last completed frame.

## Operation
- **FSM states:** IDLE, RUN.
- **Accepted bit:** `in_valid`=1 while in RUN, or `in_valid`=1 in the same cycle as `start`.
- **IDLE:**
  - `in_valid` without `start` is ignored.
  - `start` → RUN, with `rem`=0 and `bit_count`=0. The same-cycle bit, if valid, is the first bit.
- **RUN:** each accepted bit updates the state.
  - MSB-first: `rem` ← (2·`rem` + `in_bit`) mod `MOD`.
- **Remainder arithmetic:**
  - Computed in RW+1 bits as t = 2·`rem` + `in_bit`.
  - If t ≥ `MOD`, subtract `MOD` once. No divider is used.
- **Per-bit outputs:**
  - `divisible` ← (new `rem` == 0).
  - `bit_count` ← `bit_count`+1, saturating at 2^CNT_W−1.
- **Last bit** (accepted bit with `in_last`=1):
  - `done`=1 next cycle.
  - `res_rem`/`res_div` latch the new remainder/flag.
  - FSM → IDLE.
  - `rem`, `divisible` and `bit_count` hold until the next `start`.
- **`start` during RUN:** abort the current frame with no `done`, then restart exactly as `start` from IDLE. Same-cycle bit handling is identical.
- **`start` and `in_last` together with `in_valid`:** one-bit frame, so `done` follows next cycle.
- **`in_last` without `in_valid`:** ignored.
- **`res_rem`/`res_div`:** change only on `done`; held across aborts.

## Timing
- **Reset:** all outputs are 0 after reset; FSM = IDLE.
- **Latency:** `rem`, `divisible` and `bit_count` reflect an accepted bit one cycle after the bit's edge.
- **`done`:** asserted exactly one cycle after the accepted last bit, for one cycle. It coincides with updated `res_*`.
- **Throughput:** one bit per cycle. Back-to-back frames are allowed: `start` may coincide with the `done` cycle.
- **Reset mid-frame:** wins over all inputs. No `done`, and `res_*` are cleared.

## Configuration
- Macro: `SERIAL_MOD_LSB_EN`.
- **With the macro defined:**
  - Extra input `lsb_first` (1 bit), sampled only on `start`.
  - Internal weight register `w` (RW bits) is set to 1 mod `MOD` on `start`.
  - When LSB-first, each accepted bit does `rem` ← (`rem` + `in_bit`·`w`) mod `MOD` and `w` ← 2·`w` mod `MOD`, each with a single conditional subtract.
  - MSB-first frames behave as specified above.
- **Without the macro:** no `lsb_first` port and no weight register; MSB-first only.

## Structure
- **Package `serial_mod_pkg`:**
  - state enum {IDLE, RUN};
  - a function returning RW for a given `MOD`;
  - a `MOD` range check constant used by an elaboration-time assertion (`MOD` < 2 is a fatal error).
- **Sub-module `mod_add_reduce`:** combinational (a + b) mod `MOD`, valid for a, b < `MOD`. It serves both 2·`rem`+bit (a=`rem`, b=`rem`+bit folding) and the LSB-first update.

## Test plan
- `MOD`=5, MSB-first, bits 1,0,1,0 with `in_last` on the 4th:
  - `rem` sequence 1,2,0,0;
  - `divisible` 0,0,1,1;
  - `done` once, with `res_rem`=0 and `res_div`=1.
- `MOD`=5, bits 1,1,0,1 (decimal 13) → `res_rem`=3, `res_div`=0, `bit_count`=4.
- `MOD`=7, frame 1,1,1 with `in_last`, followed immediately by `start` on the `done` cycle and frame 1,1,1,0 → `res_rem`=0 then 0 (7, 14); `bit_count` restarts at 1.
- Abort: `start` after 3 bits of frame A, then 2 bits of frame B with `in_last` → only one `done`, with `res_*` from B only. `reset_n`=0 mid-frame → all outputs 0 next cycle.
- `SERIAL_MOD_LSB_EN`, `MOD`=5, `lsb_first`=1, bits 0,1,0,1 (decimal 10) → `rem` 0,2,2,0; `res_div`=1.
- `CNT_W`=3, 10-bit frame → `bit_count` saturates at 7; remainder still correct against a reference model.
